// File: rtl/flappy_pkg.sv
// Shared gameplay constants and the gap scheduler FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a. Pipe mover and collision logic import the same gap limits.
package flappy_pkg;

  // Screen geometry (480-line VGA) and legal gap-centre band.
  localparam int Y_W       = 10;
  localparam int GAP_MIN   = 60;
  localparam int GAP_MAX   = 299;
  localparam int GAP_RANGE = GAP_MAX - GAP_MIN + 1;  // must be 1..256

  // Fetch / reduce sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_REDUCE  = 3'd3,
    ST_PUSH    = 3'd4
  } sched_state_e;

  // Map a reduced value (0..GAP_RANGE-1) onto a screen Y coordinate.
  function automatic logic [Y_W-1:0] gap_y_of(input logic [8:0] reduced);
    return Y_W'(GAP_MIN) + Y_W'(reduced);
  endfunction

endpackage

// File: rtl/pipe_gap_scheduler_if.sv
// Bundle between the gap scheduler, the LFSR and the pipe spawner.
// Latency: n/a (wires only).
// Backpressure: spawner pops only while gap_valid; LFSR advances only on rnd_enable.
//   master: scheduler side (drives rnd_enable, gap_valid, gap_y, level)
//   slave : environment side (drives rnd, flush, pop)
interface pipe_gap_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int Y_W   = flappy_pkg::Y_W
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             rnd_enable;
  logic [7:0]       rnd;
  logic             flush;
  logic             pop;
  logic             gap_valid;
  logic [Y_W-1:0]   gap_y;
  logic [LVL_W-1:0] level;

  modport master (
    output rnd_enable, gap_valid, gap_y, level,
    input  rnd, flush, pop
  );

  modport slave (
    input  rnd_enable, gap_valid, gap_y, level,
    output rnd, flush, pop
  );
endinterface

// File: rtl/pipe_gap_scheduler_gap_fifo.sv
// Show-ahead FIFO of gap Y coordinates with synchronous flush and level count.
// Latency: a push is visible at head_dat/vld the cycle after its write edge.
// Backpressure: push ignored when full, pop ignored when empty; flush beats both.
//   clock/reset : rising-edge clock, async active-high reset
//   flush       : clears pointers and level
//   push/push_dat, pop : write tail / consume head
//   vld/head_dat/level/full : status and head entry (head_dat=0 when empty)
module gap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic                       vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_eff;
  logic             pop_eff;
  logic             empty;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign push_eff = push && !full;
  assign pop_eff  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);  // power-of-two depth wraps naturally
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  assign vld      = !empty;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/pipe_gap_scheduler.sv
// Pulls LFSR bytes on demand, reduces them into the legal gap band, and queues them.
// Latency: entry visible 4+floor(rnd/R) cycles after the FSM leaves IDLE.
// Backpressure: fetches only while the FIFO has room; pop ignored when empty.
//   clock/reset : rising-edge clock, async active-high reset
//   bus (master): rnd_enable/rnd to the LFSR, flush/pop/gap_valid/gap_y/level to the spawner
module pipe_gap_scheduler
  import flappy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  pipe_gap_scheduler_if.master bus
);
  localparam logic [8:0] RANGE9 = 9'(GAP_RANGE);

  sched_state_e state_q, state_d;
  logic [8:0]   work_q, work_d;
  logic         push;
  logic         fifo_full;
  logic [Y_W-1:0] push_dat;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    push    = 1'b0;
    if (bus.flush) begin
      // New game: abandon any in-flight fetch; the LFSR step already taken stays taken.
      state_d = ST_IDLE;
      work_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (!fifo_full) state_d = ST_FETCH;
        ST_FETCH:   state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          // rnd already reflects the advance taken at the FETCH edge.
          work_d  = {1'b0, bus.rnd};
          state_d = ST_REDUCE;
        end
        ST_REDUCE: begin
          // Iterative modulo by subtraction; 9-bit compare covers a range of 256.
          if (work_q >= RANGE9) work_d = work_q - RANGE9;
          else                  state_d = ST_PUSH;
        end
        ST_PUSH: begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
    end
  end

  // Decoded from the state flop; flush suppresses the advance in the same cycle.
  assign bus.rnd_enable = (state_q == ST_FETCH) && !bus.flush;

  assign push_dat = gap_y_of(work_q);

  gap_fifo #(
    .DEPTH (DEPTH),
    .W     (Y_W)
  ) u_gap_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.flush),
    .push     (push),
    .push_dat (push_dat),
    .pop      (bus.pop),
    .vld      (bus.gap_valid),
    .head_dat (bus.gap_y),
    .level    (bus.level),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_pipe_gap_scheduler.sv
module tb_pipe_gap_scheduler;
  localparam int DEPTH = 4;
  localparam int GMIN  = 60;
  localparam int R     = 240;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipe_gap_scheduler_if #(.DEPTH(DEPTH)) bus ();

  pipe_gap_scheduler #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int pops    = 0;
  int src [$];
  int exp_q [$];
  int rnd_hold = 250;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_level(input int target, input int budget, input string tag);
    int n = 0;
    while (bus.level != target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.level, target);
  endtask

  // LFSR stand-in: a register that advances only on rnd_enable. Every advance
  // predicts one FIFO entry; a flush discards all predictions still pending.
  always @(posedge clock) begin
    int v;
    if (!reset) begin
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.rnd_enable) begin
        v = (src.size() > 0) ? src.pop_front() : rnd_hold;
        bus.rnd <= v[7:0];
        exp_q.push_back(GMIN + (v % R));
        pulses <= pulses + 1;
      end
    end
  end

  // Every accepted pop must deliver the oldest outstanding prediction.
  always @(negedge clock) begin
    if (!reset && bus.pop && bus.gap_valid && !bus.flush) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_prediction", bus.gap_y, 0);
      end else begin
        chk("popped_gap_y", bus.gap_y, exp_q.pop_front());
      end
      pops <= pops + 1;
    end
  end

  initial begin
    int n;
    int p0;
    int pop0;
    int maxl;

    bus.rnd   = 8'd250;
    bus.flush = 1'b0;
    bus.pop   = 1'b0;
    repeat (3) tick();
    chk("reset_rnd_enable", bus.rnd_enable, 0);
    chk("reset_gap_valid",  bus.gap_valid,  0);
    chk("reset_gap_y",      bus.gap_y,      0);
    chk("reset_level",      bus.level,      0);

    // Constant rnd=250: first edge after release leaves IDLE, then 4+floor(250/240) more.
    p0 = pulses;
    reset = 1'b0;
    n = 0;
    while (!bus.gap_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_entry_edges", n, 5 + 250 / R);
    chk("first_gap_y", bus.gap_y, 70);
    wait_level(4, 40, "fill_const_level");
    repeat (10) tick();
    chk("one_pulse_per_entry", pulses - p0, 4);

    // Ordered sequence into an emptied FIFO, then idle while full.
    src = '{17, 239, 240, 0};
    rnd_hold = 17;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_level", bus.level, 0);
    chk("flush_gap_valid", bus.gap_valid, 0);
    wait_level(4, 60, "fill_seq_level");
    chk("seq_head", bus.gap_y, 77);
    p0 = pulses;
    repeat (20) tick();
    chk("no_fetch_when_full", pulses - p0, 0);
    chk("full_level_held", bus.level, 4);

    // Single pop from full: head advances, exactly one refill within 5 edges.
    p0 = pulses;
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("pop_level", bus.level, 3);
    chk("pop_next_head", bus.gap_y, 299);
    repeat (5) tick();
    chk("refill_level", bus.level, 4);
    chk("refill_pulses", pulses - p0, 1);

    // Pop held high with rnd=17: level stays 0/1, pops while empty do nothing.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    pop0 = pops;
    maxl = 0;
    bus.pop = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.level > maxl) maxl = bus.level;
    end
    bus.pop = 1'b0;
    chk("pop_held_max_level", maxl, 1);
    chk("pop_held_some_pops", (pops - pop0) >= 8, 1);

    // Flush in REDUCE at level 2: the in-flight 250 is dropped, next entry uses 5.
    src = '{20, 30, 250, 5};
    rnd_hold = 5;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_level(2, 40, "pre_flush_fill");
    n = 0;
    while (!bus.rnd_enable && n < 10) begin
      tick();
      n++;
    end
    chk("third_fetch_seen", bus.rnd_enable, 1);
    tick();  // CAPTURE
    tick();  // REDUCE with work=250
    bus.flush = 1'b1;
    chk("pre_flush_level", bus.level, 2);
    tick();
    bus.flush = 1'b0;
    chk("post_flush_level", bus.level, 0);
    chk("post_flush_valid", bus.gap_valid, 0);
    n = 0;
    while (!bus.gap_valid && n < 12) begin
      tick();
      n++;
    end
    chk("refetch_valid", bus.gap_valid, 1);
    chk("refetch_gap_y", bus.gap_y, 65);

    // Asynchronous reset landing in the middle of a FETCH cycle.
    n = 0;
    while (!bus.rnd_enable && n < 12) begin
      tick();
      n++;
    end
    chk("fetch_before_reset", bus.rnd_enable, 1);
    chk("level_before_reset", bus.level != 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_rnd_enable", bus.rnd_enable, 0);
    chk("async_rst_gap_valid",  bus.gap_valid,  0);
    chk("async_rst_level",      bus.level,      0);
    exp_q.delete();
    src.delete();
    rnd_hold = 33;
    #10;
    reset = 1'b0;
    n = 0;
    while (!bus.gap_valid && n < 15) begin
      tick();
      n++;
    end
    chk("resume_valid", bus.gap_valid, 1);
    chk("resume_gap_y", bus.gap_y, 93);
    pop0 = pops;
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    tick();
    chk("resume_pop_seen", pops - pop0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
